// File: rtl/cam_mux_rr_arbiter.sv
// Round-robin arbiter/sequencer for the 8:1 CAM validation mux: grants one of
// eight requesters, presents the mux line over valid/ready, drops stale grants.
module cam_mux_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       req,
    input  logic             mux_line,
    input  logic             out_ready,
    output logic [2:0]       sel,
    output logic [7:0]       grant,
    output logic             out_valid,
    output logic             out_data,
    output logic [2:0]       out_src,
    output logic             timeout,
    output logic [CNT_W-1:0] xfer_count
);

    localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        sel_q, sel_d;
    logic [7:0]        grant_q, grant_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  xfer_q, xfer_d;

    logic       xfer;
    logic       hold_expire;
    logic       release_grant;
    logic [2:0] base_ptr;
    logic [2:0] winner;

    // First set request scanning upward from p, wrapping modulo 8.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = p + 3'(i);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    assign out_valid  = (state_q == S_GRANT);
    assign out_data   = out_valid & mux_line;
    assign sel        = sel_q;
    assign out_src    = sel_q;
    assign grant      = grant_q;
    assign timeout    = timeout_q;
    assign xfer_count = xfer_q;

    assign xfer          = out_valid & out_ready;
    assign hold_expire   = (MAX_HOLD > 0) && out_valid && !xfer && (hold_q == HOLD_LAST);
    assign release_grant = xfer | hold_expire;
    // Releasing a grant re-arbitrates from the slot after the winner in the same cycle.
    assign base_ptr      = release_grant ? (sel_q + 3'd1) : ptr_q;
    assign winner        = rr_pick(req, base_ptr);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
        timeout_d = hold_expire;
        xfer_d    = xfer ? (xfer_q + CNT_W'(1)) : xfer_q;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    state_d = S_GRANT;
                    sel_d   = winner;
                    grant_d = 8'b1 << winner;
                    hold_d  = '0;
                end
            end
            S_GRANT: begin
                if (release_grant) begin
                    ptr_d  = base_ptr;
                    hold_d = '0;
                    if (|req) begin
                        sel_d   = winner;
                        grant_d = 8'b1 << winner;
                    end else begin
                        state_d = S_IDLE;
                        grant_d = '0;
                    end
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            sel_q     <= '0;
            grant_q   <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
            xfer_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            grant_q   <= grant_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
            xfer_q    <= xfer_d;
        end
    end

endmodule

// File: tb/tb_cam_mux_rr_arbiter.sv
// Self-checking bench for cam_mux_rr_arbiter: vector table, directed corner
// sequences and a randomized run against a behavioural round-robin model.
module tb_cam_mux_rr_arbiter;

    localparam int MAX_HOLD = 4;
    localparam int CNT_W    = 4;

    logic             clk;
    logic             reset;
    logic [7:0]       req;
    logic             mux_line;
    logic             out_ready;
    logic [2:0]       sel;
    logic [7:0]       grant;
    logic             out_valid;
    logic             out_data;
    logic [2:0]       out_src;
    logic             timeout;
    logic [CNT_W-1:0] xfer_count;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model: current grant index (-1 = none), priority pointer, hold age.
    int m_cur, m_ptr, m_hold, m_cnt;
    bit m_to;

    cam_mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .req(req), .mux_line(mux_line), .out_ready(out_ready),
        .sel(sel), .grant(grant), .out_valid(out_valid), .out_data(out_data),
        .out_src(out_src), .timeout(timeout), .xfer_count(xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_pick(input logic [7:0] r, input int p);
        for (int i = 0; i < 8; i++)
            if (r[(p + i) % 8]) return (p + i) % 8;
        return -1;
    endfunction

    task automatic model_reset();
        m_cur = -1; m_ptr = 0; m_hold = 0; m_cnt = 0; m_to = 0;
    endtask

    task automatic model_step(input logic [7:0] r, input logic rdy);
        bit valid, done, expire;
        valid  = (m_cur >= 0);
        done   = valid && rdy;
        expire = (MAX_HOLD > 0) && valid && !done && (m_hold == MAX_HOLD - 1);
        m_to   = expire;
        if (done) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (!valid) begin
            m_cur  = m_pick(r, m_ptr);
            m_hold = 0;
        end else if (done || expire) begin
            m_ptr  = (m_cur + 1) % 8;
            m_cur  = m_pick(r, m_ptr);
            m_hold = 0;
        end else begin
            m_hold++;
        end
    endtask

    task automatic compare_model();
        bit v;
        v = (m_cur >= 0);
        check("m_valid", 32'(out_valid), 32'(v));
        check("m_grant", 32'(grant), v ? (32'd1 << m_cur) : 32'd0);
        check("m_data", 32'(out_data), 32'(v & mux_line));
        check("m_timeout", 32'(timeout), 32'(m_to));
        check("m_xfer", 32'(xfer_count), 32'(m_cnt));
        if (v) begin
            check("m_sel", 32'(sel), 32'(m_cur));
            check("m_src", 32'(out_src), 32'(m_cur));
        end
    endtask

    // Drive at the falling edge, let one rising edge pass, sample 1 time unit later.
    task automatic step(input logic [7:0] r, input logic rdy, input logic mx);
        @(negedge clk);
        req = r; out_ready = rdy; mux_line = mx;
        @(posedge clk);
        model_step(r, rdy);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req = '0; out_ready = 1'b0; mux_line = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic [7:0] exp_grant;
        logic       exp_valid;
        int         exp_xfer;
    } vec_t;

    vec_t vecs[14];

    initial begin
        reset = 1'b1; req = '0; out_ready = 1'b0; mux_line = 1'b0;
        model_reset();

        vecs[0]  = '{8'h04, 1'b1, 8'h04, 1'b1, 0};
        vecs[1]  = '{8'h04, 1'b1, 8'h04, 1'b1, 1};
        vecs[2]  = '{8'h00, 1'b1, 8'h00, 1'b0, 2};
        vecs[3]  = '{8'h80, 1'b0, 8'h80, 1'b1, 2};
        vecs[4]  = '{8'hFF, 1'b1, 8'h01, 1'b1, 3};
        vecs[5]  = '{8'hFF, 1'b1, 8'h02, 1'b1, 4};
        vecs[6]  = '{8'hFF, 1'b1, 8'h04, 1'b1, 5};
        vecs[7]  = '{8'hFF, 1'b1, 8'h08, 1'b1, 6};
        vecs[8]  = '{8'hFF, 1'b1, 8'h10, 1'b1, 7};
        vecs[9]  = '{8'hFF, 1'b1, 8'h20, 1'b1, 8};
        vecs[10] = '{8'hFF, 1'b1, 8'h40, 1'b1, 9};
        vecs[11] = '{8'hFF, 1'b1, 8'h80, 1'b1, 10};
        vecs[12] = '{8'hFF, 1'b1, 8'h01, 1'b1, 11};
        vecs[13] = '{8'h00, 1'b0, 8'h01, 1'b1, 11};

        #12;
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_sel", 32'(sel), 32'd0);
        check("reset_src", 32'(out_src), 32'd0);
        check("reset_xfer", 32'(xfer_count), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].req, vecs[i].rdy, 1'b1);
            check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_xfer", i), 32'(xfer_count), 32'(vecs[i].exp_xfer));
        end

        // Hold timeout: four valid cycles, then a one-cycle pulse with regrant.
        do_reset();
        step(8'h10, 1'b0, 1'b1);
        check("to_grant0", 32'(grant), 32'h10);
        check("to_sel0", 32'(sel), 32'd4);
        for (int k = 1; k < 4; k++) begin
            step(8'h10, 1'b0, 1'b1);
            check($sformatf("to_valid%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("to_quiet%0d", k), 32'(timeout), 32'd0);
        end
        step(8'h10, 1'b0, 1'b1);
        check("to_pulse", 32'(timeout), 32'd1);
        check("to_regrant", 32'(grant), 32'h10);
        check("to_xfer", 32'(xfer_count), 32'd0);

        // Transfer in the last allowed cycle beats the timeout.
        for (int k = 0; k < 3; k++) step(8'h10, 1'b0, 1'b1);
        check("last_pulse_clear", 32'(timeout), 32'd0);
        step(8'h00, 1'b1, 1'b1);
        check("last_xfer", 32'(xfer_count), 32'd1);
        check("last_no_to", 32'(timeout), 32'd0);
        check("last_idle", 32'(out_valid), 32'd0);
        step(8'h00, 1'b0, 1'b0);
        check("last_no_to2", 32'(timeout), 32'd0);

        // Withdrawal ignored until the transfer.
        step(8'h20, 1'b0, 1'b0);
        check("wd_grant5", 32'(grant), 32'h20);
        step(8'h02, 1'b0, 1'b0);
        check("wd_hold1", 32'(grant), 32'h20);
        step(8'h02, 1'b0, 1'b0);
        check("wd_hold2", 32'(grant), 32'h20);
        step(8'h02, 1'b1, 1'b0);
        check("wd_grant1", 32'(grant), 32'h02);

        // Asynchronous reset mid-grant, no clock edge in between.
        step(8'h81, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("async_grant", 32'(grant), 32'd0);
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_xfer", 32'(xfer_count), 32'd0);
        check("async_data", 32'(out_data), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        step(8'h81, 1'b0, 1'b1);
        check("async_first", 32'(grant), 32'h01);

        // Counter wrap at 2^CNT_W-1.
        do_reset();
        step(8'hFF, 1'b1, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            step(8'hFF, 1'b1, 1'b0);
            if (k == 15) check("wrap_max", 32'(xfer_count), 32'd15);
            if (k == 16) check("wrap_zero", 32'(xfer_count), 32'd0);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] r;
            case ($urandom_range(0, 3))
                0: r = 8'h00;
                1: r = 8'(1 << $urandom_range(0, 7));
                default: r = 8'($urandom);
            endcase
            step(r, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/cam_mux_rr_arbiter.md
Name: cam_mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the 8:1 select mux in the CAM validation datapath.
- Eight requesters compete for the single mux output line. The block drives the 3-bit mux selector and a one-hot grant.
- It presents the selected line to one consumer over a valid/ready handshake.
- A hold-timeout releases a grant that the consumer never accepts.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant may present out_valid without a transfer; 0 disables the timeout.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  8  level request per requester; bit i corresponds to mux input line i.
- mux_line  input  1  output line returned from the 8:1 mux.
- out_ready  input  1  consumer accepts the current item.
- sel  output  3  mux selector bits; the binary index of the granted requester.
- grant  output  8  one-hot grant; all zero when idle.
- out_valid  output  1  the presented data bit is valid.
- out_data  output  1  mux_line when out_valid=1, else 0 (combinational gate).
- out_src  output  3  index of the current grant (equal to sel).
- timeout  output  1  one-cycle pulse when a grant is dropped by timeout.
- xfer_count  output  CNT_W  number of completed transfers; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, any state): the following take effect immediately.
  - state=IDLE, ptr=0, grant=0, sel=0, out_src=0.
  - out_valid=0, out_data=0, timeout=0, hold_cnt=0, xfer_count=0.
- States:
  - IDLE: no grant outstanding.
  - GRANT: grant, sel and out_src registered and stable; out_valid=1.
- Arbitration:
  - Winner is the first set req bit found scanning ptr, ptr+1, ..., ptr+7, modulo 8.
  - ptr is the highest-priority index.
- IDLE transitions:
  - req!=0: go to GRANT next cycle with the winner registered. Latency is 1 cycle from req to grant/out_valid.
  - req==0: stay in IDLE.
- GRANT, transfer (out_valid & out_ready):
  - xfer_count increments.
  - ptr becomes (granted index + 1) mod 8.
  - Re-arbitrate in the same cycle with the new ptr against current req:
    - any req: stay in GRANT with the new winner next cycle (back-to-back, no idle bubble);
    - else go to IDLE.
  - The previous winner may win again only if it is the sole requester.
- GRANT, no transfer: hold_cnt increments. grant and sel do not change.
- Request withdrawal: a granted requester dropping req is ignored. The grant stands until transfer or timeout.
- Timeout (MAX_HOLD>0):
  - hold_cnt clears on every new grant.
  - If hold_cnt==MAX_HOLD-1 and there is no transfer that cycle, the grant is released. Consequently out_valid is high for at most MAX_HOLD consecutive cycles per grant.
  - ptr advances as for a transfer; re-arbitration follows as for a transfer.
  - timeout=1 for exactly the following cycle.
  - xfer_count is unchanged.
- Timeout vs. transfer: a transfer in the final allowed cycle wins; no timeout is raised.
- hold_cnt width: $clog2(MAX_HOLD+1), minimum 1.
- xfer_count at 2^CNT_W-1 wraps to 0 on the next transfer.
- out_data is never registered. It follows mux_line combinationally while out_valid=1.

Test Plan:
1. Reset, then req=8'b0000_0100, out_ready=1 → next cycle: grant=8'h04, sel=2, out_valid=1. Following cycle: xfer_count=1, ptr=3, and a regrant to 2 (sole requester).
2. ptr=0, req=8'hFF, out_ready=1 held → grants in order 0,1,2,...,7,0 on consecutive cycles; out_valid continuously 1; xfer_count=9 after 9 cycles.
3. MAX_HOLD=4, req=8'h10, out_ready=0 → out_valid=1 with sel=4 for exactly 4 cycles, then timeout pulse for 1 cycle. If req is still 8'h10, a regrant to 4 follows; xfer_count=0.
4. MAX_HOLD=4, out_ready asserted in the 4th grant cycle → transfer counted, timeout stays 0.
5. Granted to 5 with out_ready=0; drop req[5] and raise req[1] → grant stays 8'h20 until out_ready=1, then grant=8'h02.
6. Assert reset mid-GRANT with req=8'h81 → grant=0, out_valid=0 and xfer_count=0 immediately, without waiting for clk. After release, the first grant goes to 0 (ptr=0).
